// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the ALU result always wins the single
// write port, while loads are sign/zero-extended on entry and parked in a
// 2-entry FIFO that drains whenever the ALU leaves the port free.
module wb_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ALU_V,
    input  logic [4:0]  ALU_RD,
    input  logic [31:0] ALU_D,
    input  logic        LD_V,
    input  logic [4:0]  LD_RD,
    input  logic [2:0]  LD_F3,
    input  logic [1:0]  LD_OFF,
    input  logic [31:0] LD_D,
    output logic        LD_RDY,
    output logic [4:0]  AW,
    output logic [31:0] D,
    output logic        WE,
    output logic [1:0]  CNT
);

    // Load funct3 encodings that need extraction; everything else passes the word through.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [1:0]  r_cnt;
    logic        r_wptr;
    logic        r_rptr;
    logic [4:0]  r_fifo_rd [0:1];
    logic [31:0] r_fifo_d  [0:1];
    logic [4:0]  r_aw;
    logic [31:0] r_d;
    logic        r_we;

    logic        w_ld_rdy;
    logic        w_alu_req;
    logic        w_enq;
    logic        w_deq;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    // Rd=0 writes are architecturally void, so they never count as requests.
    assign w_ld_rdy  = (r_cnt < 2'd2);
    assign w_alu_req = ALU_V && (ALU_RD != 5'd0);
    assign w_enq     = LD_V && w_ld_rdy && (LD_RD != 5'd0);
    assign w_deq     = !w_alu_req && (r_cnt != 2'd0);

    // Select the addressed byte/halfword of the raw load word and extend it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
        w_byte    = LD_D[7:0];
        w_half    = LD_OFF[1] ? LD_D[31:16] : LD_D[15:0];
        w_ld_data = LD_D;
        case (LD_OFF)
            2'd1:    w_byte = LD_D[15:8];
            2'd2:    w_byte = LD_D[23:16];
            2'd3:    w_byte = LD_D[31:24];
            default: w_byte = LD_D[7:0];
        endcase
        case (LD_F3)
            F3_LB:   w_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  w_ld_data = {24'd0, w_byte};
            F3_LH:   w_ld_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = LD_D;
        endcase
    end

    // FIFO pointers and occupancy; a simultaneous enqueue and dequeue leaves the count alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= 2'd0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            if (w_enq) r_wptr <= ~r_wptr;
            if (w_deq) r_rptr <= ~r_rptr;
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage written at enqueue with the already-extracted data.
    always_ff @(posedge CLK) begin
        // NOTE: payload storage is deliberately not reset; r_cnt gates every read, so stale entries are never visible.
        if (w_enq) begin
            r_fifo_rd[r_wptr] <= LD_RD;
            r_fifo_d[r_wptr]  <= w_ld_data;
        end
    end

    // Registered write port: ALU first, then FIFO head; AW/D hold when idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_aw <= 5'd0;
            r_d  <= 32'd0;
            r_we <= 1'b0;
        end else if (w_alu_req) begin
            r_aw <= ALU_RD;
            r_d  <= ALU_D;
            r_we <= 1'b1;
        end else if (w_deq) begin
            r_aw <= r_fifo_rd[r_rptr];
            r_d  <= r_fifo_d[r_rptr];
            r_we <= 1'b1;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign LD_RDY = w_ld_rdy;
    assign AW     = r_aw;
    assign D      = r_d;
    assign WE     = r_we;
    assign CNT    = r_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a table of load-extraction vectors plus
// hand-written sequences for arbitration, FIFO fill/stall, and async reset.
module tb_wb_arbiter;

    logic        CLK;
    logic        RST;
    logic        ALU_V;
    logic [4:0]  ALU_RD;
    logic [31:0] ALU_D;
    logic        LD_V;
    logic [4:0]  LD_RD;
    logic [2:0]  LD_F3;
    logic [1:0]  LD_OFF;
    logic [31:0] LD_D;
    logic        LD_RDY;
    logic [4:0]  AW;
    logic [31:0] D;
    logic        WE;
    logic [1:0]  CNT;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] exp_d;
    } ld_vec_t;

    ld_vec_t vecs [11];

    wb_arbiter dut (
        .CLK    (CLK),
        .RST    (RST),
        .ALU_V  (ALU_V),
        .ALU_RD (ALU_RD),
        .ALU_D  (ALU_D),
        .LD_V   (LD_V),
        .LD_RD  (LD_RD),
        .LD_F3  (LD_F3),
        .LD_OFF (LD_OFF),
        .LD_D   (LD_D),
        .LD_RDY (LD_RDY),
        .AW     (AW),
        .D      (D),
        .WE     (WE),
        .CNT    (CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ALU_V  = 1'b0;
        ALU_RD = 5'd0;
        ALU_D  = 32'd0;
        LD_V   = 1'b0;
        LD_RD  = 5'd0;
        LD_F3  = 3'd0;
        LD_OFF = 2'd0;
        LD_D   = 32'd0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] data);
        LD_V   = 1'b1;
        LD_RD  = rd;
        LD_F3  = f3;
        LD_OFF = off;
        LD_D   = data;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] data);
        ALU_V  = 1'b1;
        ALU_RD = rd;
        ALU_D  = data;
    endtask

    initial begin
        vecs[0]  = '{3'b000, 2'd2, 32'h0080FF00, 5'd3,  32'hFFFFFF80};
        vecs[1]  = '{3'b100, 2'd2, 32'h0080FF00, 5'd3,  32'h00000080};
        vecs[2]  = '{3'b001, 2'd2, 32'h80011234, 5'd6,  32'hFFFF8001};
        vecs[3]  = '{3'b101, 2'd2, 32'h80011234, 5'd6,  32'h00008001};
        vecs[4]  = '{3'b010, 2'd3, 32'hDEADBEEF, 5'd31, 32'hDEADBEEF};
        vecs[5]  = '{3'b000, 2'd0, 32'h1234567F, 5'd1,  32'h0000007F};
        vecs[6]  = '{3'b000, 2'd3, 32'hA5000000, 5'd2,  32'hFFFFFFA5};
        vecs[7]  = '{3'b001, 2'd1, 32'h0000F00D, 5'd9,  32'hFFFFF00D};
        vecs[8]  = '{3'b011, 2'd1, 32'h13579BDF, 5'd10, 32'h13579BDF};
        vecs[9]  = '{3'b100, 2'd1, 32'h0000C300, 5'd14, 32'h000000C3};
        vecs[10] = '{3'b110, 2'd2, 32'h11112222, 5'd15, 32'h11112222};

        // Reset state, observed before any clock edge.
        idle();
        RST = 1'b1;
        #2;
        check("reset WE", {31'd0, WE}, 32'd0);
        check("reset AW", {27'd0, AW}, 32'd0);
        check("reset D", D, 32'd0);
        check("reset CNT", {30'd0, CNT}, 32'd0);
        check("reset LD_RDY", {31'd0, LD_RDY}, 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // Single ALU write: visible on the next edge, gone the edge after.
        alu(5'd5, 32'h12345678);
        tick();
        idle();
        check("alu AW", {27'd0, AW}, 32'd5);
        check("alu D", D, 32'h12345678);
        check("alu WE", {31'd0, WE}, 32'd1);
        tick();
        check("alu WE drop", {31'd0, WE}, 32'd0);
        check("alu AW hold", {27'd0, AW}, 32'd5);

        // Extraction table: enqueue, no bypass, write on the following edge.
        for (int i = 0; i < 11; i++) begin
            load(vecs[i].rd, vecs[i].f3, vecs[i].off, vecs[i].data);
            check($sformatf("vec%0d LD_RDY", i), {31'd0, LD_RDY}, 32'd1);
            tick();
            idle();
            check($sformatf("vec%0d CNT enq", i), {30'd0, CNT}, 32'd1);
            check($sformatf("vec%0d no bypass", i), {31'd0, WE}, 32'd0);
            tick();
            check($sformatf("vec%0d WE", i), {31'd0, WE}, 32'd1);
            check($sformatf("vec%0d AW", i), {27'd0, AW}, {27'd0, vecs[i].rd});
            check($sformatf("vec%0d D", i), D, vecs[i].exp_d);
            check($sformatf("vec%0d CNT deq", i), {30'd0, CNT}, 32'd0);
            tick();
            check($sformatf("vec%0d WE idle", i), {31'd0, WE}, 32'd0);
            check($sformatf("vec%0d D hold", i), D, vecs[i].exp_d);
        end

        // Same rd from ALU and load in one cycle: ALU first, then the load.
        alu(5'd4, 32'h00000001);
        load(5'd4, 3'b010, 2'd0, 32'h00000002);
        tick();
        idle();
        check("samerd 1 AW", {27'd0, AW}, 32'd4);
        check("samerd 1 D", D, 32'h00000001);
        check("samerd 1 CNT", {30'd0, CNT}, 32'd1);
        tick();
        check("samerd 2 WE", {31'd0, WE}, 32'd1);
        check("samerd 2 D", D, 32'h00000002);
        check("samerd 2 CNT", {30'd0, CNT}, 32'd0);
        tick();

        // Enqueue and dequeue on the same edge keep CNT at 1.
        load(5'd11, 3'b010, 2'd0, 32'h0000000B);
        tick();
        load(5'd12, 3'b010, 2'd0, 32'h0000000C);
        check("encdeq CNT pre", {30'd0, CNT}, 32'd1);
        tick();
        idle();
        check("encdeq AW", {27'd0, AW}, 32'd11);
        check("encdeq CNT", {30'd0, CNT}, 32'd1);
        tick();
        check("encdeq 2nd AW", {27'd0, AW}, 32'd12);
        check("encdeq 2nd D", D, 32'h0000000C);
        check("encdeq 2nd CNT", {30'd0, CNT}, 32'd0);
        tick();

        // ALU with rd=0 is no request, so the FIFO drains.
        load(5'd13, 3'b010, 2'd0, 32'h0000000D);
        tick();
        idle();
        alu(5'd0, 32'h0000FFFF);
        tick();
        idle();
        check("alu rd0 drain WE", {31'd0, WE}, 32'd1);
        check("alu rd0 drain AW", {27'd0, AW}, 32'd13);
        check("alu rd0 drain D", D, 32'h0000000D);
        check("alu rd0 drain CNT", {30'd0, CNT}, 32'd0);
        tick();
        check("alu rd0 idle WE", {31'd0, WE}, 32'd0);

        // Both requests to rd=0: nothing written, nothing buffered.
        load(5'd0, 3'b010, 2'd0, 32'h00000055);
        alu(5'd0, 32'h00000066);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rd0 WE %0d", k), {31'd0, WE}, 32'd0);
            check($sformatf("rd0 CNT %0d", k), {30'd0, CNT}, 32'd0);
        end
        idle();
        tick();

        // ALU holds the port 4 cycles while loads fill the FIFO and a third stalls.
        alu(5'd7, 32'h00000070);
        load(5'd8, 3'b010, 2'd0, 32'h00000080);
        tick();
        check("fill e1 AW", {27'd0, AW}, 32'd7);
        check("fill e1 CNT", {30'd0, CNT}, 32'd1);
        load(5'd9, 3'b010, 2'd0, 32'h00000090);
        tick();
        check("fill e2 CNT", {30'd0, CNT}, 32'd2);
        check("fill e2 LD_RDY", {31'd0, LD_RDY}, 32'd0);
        load(5'd10, 3'b010, 2'd0, 32'h000000A0);
        tick();
        check("fill e3 CNT", {30'd0, CNT}, 32'd2);
        check("fill e3 AW", {27'd0, AW}, 32'd7);
        check("fill e3 LD_RDY", {31'd0, LD_RDY}, 32'd0);
        tick();
        check("fill e4 CNT", {30'd0, CNT}, 32'd2);
        check("fill e4 WE", {31'd0, WE}, 32'd1);
        check("fill e4 AW", {27'd0, AW}, 32'd7);
        idle();
        check("full deq LD_RDY", {31'd0, LD_RDY}, 32'd0);
        tick();
        check("drain1 AW", {27'd0, AW}, 32'd8);
        check("drain1 D", D, 32'h00000080);
        check("drain1 CNT", {30'd0, CNT}, 32'd1);
        tick();
        check("drain2 WE", {31'd0, WE}, 32'd1);
        check("drain2 AW", {27'd0, AW}, 32'd9);
        check("drain2 D", D, 32'h00000090);
        check("drain2 CNT", {30'd0, CNT}, 32'd0);
        tick();
        check("drain done WE", {31'd0, WE}, 32'd0);
        check("stalled load absent", {27'd0, AW}, 32'd9);

        // Async reset with a full FIFO: immediate clear, nothing written afterwards.
        alu(5'd7, 32'h00000077);
        load(5'd20, 3'b010, 2'd0, 32'h00000020);
        tick();
        load(5'd21, 3'b010, 2'd0, 32'h00000021);
        tick();
        check("prerst CNT", {30'd0, CNT}, 32'd2);
        idle();
        RST = 1'b1;
        #1;
        check("rst WE", {31'd0, WE}, 32'd0);
        check("rst CNT", {30'd0, CNT}, 32'd0);
        check("rst LD_RDY", {31'd0, LD_RDY}, 32'd1);
        check("rst AW", {27'd0, AW}, 32'd0);
        check("rst D", D, 32'd0);
        #3;
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("postrst WE %0d", k), {31'd0, WE}, 32'd0);
            check($sformatf("postrst CNT %0d", k), {30'd0, CNT}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
